// File: rtl/pc_unit.sv
// pc_unit: program counter, data address register and a single-outstanding
// memory request controller (IDLE/BUSY).
//
// Optional feature: define PC_UNIT_WRAP_FAULT_EN to make an increment from
// the all-ones PC hold the PC and raise a sticky fault flag. Without it the
// PC wraps to 0 and fault is tied low.
//
// Handshake: mem_req is sampled only in IDLE; the command/address are latched
// and presented on mem_cmd/mem_addr for the whole BUSY period; mem_ready in
// BUSY completes the access and done pulses for the following cycle. mem_ready
// in IDLE and mem_req in BUSY are ignored.
module pc_unit #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic [1:0]        pc_sel,
  input  logic [DATA_W-1:0] offset,
  input  logic [ADDR_W-1:0] target,
  input  logic              load_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              addr_sel,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_link,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_cmd,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0]        CMD_NONE  = 2'b00;
  localparam logic [1:0]        CMD_READ  = 2'b01;
  localparam logic [1:0]        CMD_WRITE = 2'b10;
  localparam logic [ADDR_W-1:0] PC_MAX    = '1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] daddr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_src;
  logic [1:0]        cmd_q;
  logic              done_q;
  state_t            state_q;
  state_t            state_next;

  // Upper operand bits are architecturally ignored.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{offset[DATA_W-1:ADDR_W], data_in[DATA_W-1:ADDR_W]};

  assign pc        = pc_q;
  assign pc_link   = pc_q + ADDR_W'(1);
  assign addr_src  = addr_sel ? pc_q : daddr_q;
  assign done      = done_q;
  assign state_dbg = state_q;

`ifdef PC_UNIT_WRAP_FAULT_EN
  logic wrap_hit;
  logic fault_q;

  // A wrap attempt is an increment request while the PC is all-ones.
  always_comb begin
    wrap_hit = load_pc && (pc_sel == 2'b00) && (pc_q == PC_MAX);
  end

  // Sticky wrap fault, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (wrap_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Next PC selection; arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    pc_next = pc_q;
    if (load_pc) begin
      case (pc_sel)
        2'b00: begin
`ifdef PC_UNIT_WRAP_FAULT_EN
          if (pc_q != PC_MAX) begin
            pc_next = pc_link;
          end
`else
          pc_next = pc_link;
`endif
        end
        2'b01:   pc_next = pc_q + offset[ADDR_W-1:0];
        2'b10:   pc_next = target;
        default: pc_next = RESET_PC;
      endcase
    end
  end

  // PC and data address registers; both update in either FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      daddr_q <= '0;
    end else begin
      pc_q <= pc_next;
      if (load_addr) begin
        daddr_q <= data_in[ADDR_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Request latch and completion pulse; a reset mid-access drops it silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= CMD_NONE;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == BUSY) && mem_ready;
      if ((state_q == IDLE) && mem_req) begin
        cmd_q  <= mem_we ? CMD_WRITE : CMD_READ;
        addr_q <= addr_src;
      end
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_next = state_q;
    mem_cmd    = CMD_NONE;
    mem_addr   = addr_src;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_cmd  = cmd_q;
        mem_addr = addr_q;
        busy     = 1'b1;
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized + directed bench for pc_unit with a reference model
// and two expected queues (per-cycle outputs, completed memory transactions).
module tb_pc_unit;

  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int AMOD = 1 << AW;
  localparam int RPC  = 0;

  logic          clk;
  logic          reset;
  logic          load_pc;
  logic [1:0]    pc_sel;
  logic [DW-1:0] offset;
  logic [AW-1:0] target;
  logic          load_addr;
  logic [DW-1:0] data_in;
  logic          addr_sel;
  logic          mem_req;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_link;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_cmd;
  logic          busy;
  logic          done;
  logic          fault;
  logic          state_dbg;

  pc_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .pc_sel(pc_sel),
    .offset(offset), .target(target), .load_addr(load_addr),
    .data_in(data_in), .addr_sel(addr_sel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ready(mem_ready), .pc(pc), .pc_link(pc_link),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd), .busy(busy), .done(done),
    .fault(fault), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // cyc word: {done, busy, fault, cmd[1:0], addr[8:0], link[8:0], pc[8:0]}
  logic [31:0] exp_q[$];
  // txn word: {cmd[1:0], addr[8:0]}
  logic [10:0] txn_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: abstract machine state after the most recent edge.
  int m_pc, m_da, m_addr, m_cmd;
  bit m_busy, m_done, m_fault, m_valid;
  initial begin
    m_pc = 0; m_da = 0; m_addr = 0; m_cmd = 0;
    m_busy = 0; m_done = 0; m_fault = 0; m_valid = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit lpc, input logic [1:0] sel,
                       input logic [DW-1:0] off, input logic [AW-1:0] tgt,
                       input bit la, input logic [DW-1:0] din, input bit asel,
                       input bit req, input bit we, input bit rdy);
    int so;
    int n_pc;
    int e_addr;
    @(posedge clk);
    #2;
    reset = rst; load_pc = lpc; pc_sel = sel; offset = off; target = tgt;
    load_addr = la; data_in = din; addr_sel = asel; mem_req = req;
    mem_we = we; mem_ready = rdy;

    // Expected outputs for this cycle (current state, current inputs).
    if (m_valid) begin
      e_addr = m_busy ? m_addr : (asel ? m_pc : m_da);
      exp_q.push_back({m_done, m_busy, m_fault, 2'(m_busy ? m_cmd : 0),
                       AW'(e_addr), AW'((m_pc + 1) % AMOD), AW'(m_pc)});
    end

    // Advance the model across the coming edge.
    if (rst) begin
      if (m_busy) void'(txn_q.pop_back());
      m_pc = RPC; m_da = 0; m_busy = 0; m_cmd = 0; m_done = 0; m_fault = 0;
      m_valid = 1;
    end else begin
      n_pc = m_pc;
      if (lpc) begin
        case (sel)
          2'd0: begin
`ifdef PC_UNIT_WRAP_FAULT_EN
            if (m_pc == AMOD - 1) m_fault = 1;
            else n_pc = m_pc + 1;
`else
            n_pc = (m_pc + 1) % AMOD;
`endif
          end
          2'd1: begin
            so   = int'($signed(off));
            n_pc = ((m_pc + so) % AMOD + AMOD) % AMOD;
          end
          2'd2:    n_pc = int'(tgt);
          default: n_pc = RPC;
        endcase
      end
      m_done = m_busy && rdy;
      if (m_busy) begin
        if (rdy) m_busy = 0;
      end else if (req) begin
        m_busy = 1;
        m_cmd  = we ? 2 : 1;
        m_addr = asel ? m_pc : m_da;
        txn_q.push_back({2'(m_cmd), AW'(m_addr)});
      end
      if (la) m_da = int'(din) % AMOD;
      m_pc = n_pc;
    end
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 0, 0, 0, rdy);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic [10:0] t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",       32'(pc),        32'(e[8:0]));
      check("pc_link",  32'(pc_link),   32'(e[17:9]));
      check("mem_addr", 32'(mem_addr),  32'(e[26:18]));
      check("mem_cmd",  32'(mem_cmd),   32'(e[28:27]));
      check("fault",    32'(fault),     32'(e[29]));
      check("busy",     32'(busy),      32'(e[30]));
      check("state",    32'(state_dbg), 32'(e[30]));
      check("done",     32'(done),      32'(e[31]));
    end
    if (!reset && mem_ready && (mem_cmd != 2'b00)) begin
      if (txn_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL txn_unexpected: got cmd=%0h addr=%0h expected none", mem_cmd, mem_addr);
      end else begin
        t = txn_q.pop_front();
        check("txn", 32'({mem_cmd, mem_addr}), 32'(t));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; load_pc = 0; pc_sel = 0; offset = 0; target = 0; load_addr = 0;
    data_in = 0; addr_sel = 0; mem_req = 0; mem_we = 0; mem_ready = 0;

    // Reset then three increments.
    drive(1, 0, 2'd0, '0, '0, 0, '0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 2'd0, '0, '0, 0, '0, 0, 0, 0, 0);
    idle(0);

    // Relative and absolute loads.
    drive(0, 1, 2'd2, '0, 9'd5, 0, '0, 0, 0, 0, 0);
    drive(0, 1, 2'd1, 16'hFFFE, '0, 0, '0, 0, 0, 0, 0);
    drive(0, 1, 2'd2, '0, 9'h1F0, 0, '0, 0, 0, 0, 0);
    idle(0);

    // Write from the data address, held through BUSY while inputs move.
    drive(0, 0, 2'd0, '0, '0, 1, 16'h0123, 0, 0, 0, 0);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 0, 1, 1, 0);
    drive(0, 1, 2'd0, '0, '0, 0, '0, 1, 1, 0, 0);
    drive(0, 0, 2'd0, '0, '0, 1, 16'h0042, 1, 1, 0, 0);
    drive(0, 1, 2'd2, '0, 9'h0AA, 0, '0, 1, 0, 0, 0);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 1, 0, 0, 1);
    idle(1);
    idle(1);

    // Increment from all-ones, then an absolute load.
    drive(0, 1, 2'd2, '0, 9'h1FF, 0, '0, 0, 0, 0, 0);
    drive(0, 1, 2'd0, '0, '0, 0, '0, 0, 0, 0, 0);
    drive(0, 1, 2'd0, '0, '0, 0, '0, 0, 0, 0, 0);
    drive(0, 1, 2'd2, '0, 9'h010, 0, '0, 0, 0, 0, 0);
    idle(0);

    // Reset abandons a read; then back-to-back accesses.
    drive(0, 0, 2'd0, '0, '0, 0, '0, 1, 1, 0, 0);
    drive(1, 1, 2'd1, 16'h0007, '0, 1, 16'h0055, 1, 1, 1, 1);
    idle(0);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 1, 1, 1, 0);
    idle(1);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 0, 1, 0, 0);
    idle(1);
    idle(0);
    drive(0, 0, 2'd0, '0, '0, 0, '0, 1, 1, 1, 0);
    idle(1);
    idle(0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            16'($urandom),
            ($urandom_range(0, 5) == 0) ? 9'h1FF : 9'($urandom),
            1'($urandom_range(0, 1)),
            16'($urandom),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0));
    end

    // Drain any outstanding access.
    repeat (3) idle(1);
    @(negedge clk);
    #1;
    check("txn_drain", 32'(txn_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
